ofm_drain: RTL and testbench

OFM_DRAIN -- requirements
Module: ofm_drain

---
 rtl/ofm_drain_pkg.sv | 46 ++++
 rtl/ofm_drain_fifo.sv | 51 +++++
 rtl/ofm_drain.sv | 116 +++++++++++
 tb/tb_ofm_drain.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_drain_pkg.sv
// Shared constants and element conditioning for the output-feature-map drain.
// Latency: n/a (package). Backpressure: n/a.
// Holds default parameters, the stored element width derivation and the
// shift/saturate helper. Macro OFM_DRAIN_SAT_EN selects the conditioned path.
package ofm_drain_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int OWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int SHIFT_DEF  = 8;
  localparam int QWIDTH_DEF = 16;

`ifdef OFM_DRAIN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Width of each stored/emitted element.
  function automatic int calc_dwidth(input int owidth, input int qwidth);
    return SAT_EN ? qwidth : owidth;
  endfunction

  // Floor shift (arithmetic) followed by clamp to a signed qwidth range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] x,
                                                    input int shift,
                                                    input int qwidth);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = x >>> shift;
    hi = (64'sd1 <<< (qwidth - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (qwidth - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Element conditioning applied right before the row enters storage.
  function automatic logic signed [63:0] condition_elem(input logic signed [63:0] x,
                                                         input int shift,
                                                         input int qwidth);
    return SAT_EN ? shift_sat(x, shift, qwidth) : x;
  endfunction

endpackage

// File: rtl/ofm_drain_fifo.sv
// Row FIFO with first-word fall-through read port.
// Latency: written entry visible on rd_data the cycle after the write edge.
// Backpressure: writes beyond capacity are ignored unless a read frees a slot the same cycle.
// Ports: clk/rst (sync, active-high), wr_en/wr_data, rd_en/rd_data (head), count (entries held).
module sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_ok;
  logic          wr_ok;

  assign rd_ok   = rd_en && (count != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_ok   = wr_en && ((count != CW'(DEPTH)) || rd_ok);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/ofm_drain.sv
// Deskews per-column results from the array bottom edge into rows and queues them.
// Latency: column 0 captured at edge t0 -> row pushed at t0+WIDTH, out_valid the next cycle.
// Backpressure: none on input; rows arriving to a full FIFO with no pop are dropped (overflow).
// Ports: clk, rst (sync active-high); ofm_vld/ofm per-column inputs; out_valid/out_ready/
// out_data head row (FWFT); count rows held; overflow/skew_err sticky flags, clr_err clears.
// Macro OFM_DRAIN_SAT_EN: elements are shifted by SHIFT and saturated to QWIDTH before storage.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int OWIDTH = OWIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int SHIFT  = SHIFT_DEF,
  parameter  int QWIDTH = QWIDTH_DEF,
  localparam int DWIDTH = calc_dwidth(OWIDTH, QWIDTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ofm_vld,
  input  logic signed [OWIDTH-1:0] ofm [WIDTH],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data [WIDTH],
  output logic [CW-1:0]            count,
  output logic                     overflow,
  output logic                     skew_err,
  input  logic                     clr_err
);

  logic [WIDTH-1:0]         dly_vld;
  logic signed [OWIDTH-1:0] dly_dat [WIDTH];

  // Column w arrives w cycles after column 0, so it gets WIDTH-w stages
  // (capture + WIDTH-1-w delays) and all columns line up at the output.
  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    localparam int NST = WIDTH - w;
    logic [NST-1:0]           v_sr;
    logic signed [OWIDTH-1:0] d_sr [NST];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_sr <= '0;
      end else begin
        v_sr[0] <= ofm_vld[w];
        for (int s = 1; s < NST; s++) v_sr[s] <= v_sr[s-1];
      end
    end

    always_ff @(posedge clk) begin
      d_sr[0] <= ofm[w];
      for (int s = 1; s < NST; s++) d_sr[s] <= d_sr[s-1];
    end

    assign dly_vld[w] = v_sr[NST-1];
    assign dly_dat[w] = d_sr[NST-1];
  end

  logic row_full;
  logic row_part;
  logic pop;
  logic push;
  logic drop;

  assign row_full = &dly_vld;
  assign row_part = (|dly_vld) && !row_full;
  assign pop      = out_valid && out_ready;
  assign push     = row_full && ((count != CW'(DEPTH)) || pop);
  assign drop     = row_full && !push;

  logic [WIDTH*DWIDTH-1:0] wr_row;
  logic [WIDTH*DWIDTH-1:0] rd_row;

  always_comb begin
    wr_row = '0;
    for (int w = 0; w < WIDTH; w++) begin
      wr_row[w*DWIDTH +: DWIDTH] = DWIDTH'(condition_elem(64'(dly_dat[w]), SHIFT, QWIDTH));
    end
  end

  sync_fifo #(
    .DW    (WIDTH*DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_row),
    .rd_en   (pop),
    .rd_data (rd_row),
    .count   (count)
  );

  assign out_valid = (count != '0);

  // Storage is not reset, so the head is masked while empty to read as zero.
  always_comb begin
    for (int w = 0; w < WIDTH; w++) begin
      out_data[w] = out_valid ? rd_row[w*DWIDTH +: DWIDTH] : '0;
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (row_part)     skew_err <= 1'b1;
      else if (clr_err) skew_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofm_drain.sv
// Self-checking bench for ofm_drain: scoreboard of expected rows, one task per scenario.
module tb_ofm_drain;

  localparam int WIDTH = 8;
`ifdef OFM_DRAIN_SAT_EN
  localparam int DW = 16;
`else
  localparam int DW = 32;
`endif

  typedef logic signed [DW-1:0] row_t [WIDTH];

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     ofm_vld;
  logic signed [31:0]   ofm [WIDTH];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data [WIDTH];
  logic [2:0]           count;
  logic                 overflow;
  logic                 skew_err;
  logic                 clr_err;

  ofm_drain #(
    .WIDTH(WIDTH), .OWIDTH(32), .DEPTH(4), .SHIFT(8), .QWIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .ofm_vld(ofm_vld), .ofm(ofm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .skew_err(skew_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int first_vld;
  logic signed [31:0] rows [8][WIDTH];
  row_t exp_q[$];

  // Reference model of element conditioning.
  function automatic logic signed [DW-1:0] exp_elem(input logic signed [31:0] x);
`ifdef OFM_DRAIN_SAT_EN
    longint s;
    s = longint'(x) >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return DW'(s);
`else
    return x;
`endif
  endfunction

  function automatic row_t exp_row(input int r);
    row_t e;
    for (int w = 0; w < WIDTH; w++) e[w] = exp_elem(rows[r][w]);
    return e;
  endfunction

  // Drives n rows with column w of row r sampled at edge T+r+w.
  // Cycle c is driven at a negedge and captured at edge T+c. out_ready is high only
  // in cycle pop_cyc. ncyc>=0 truncates the waveform. first_vld records the first
  // cycle index whose preceding negedge showed out_valid high.
  task automatic drive_rows(input int n, input int skip_col, input int pop_cyc, input int ncyc);
    int last;
    last = (ncyc < 0) ? n + WIDTH - 1 : ncyc - 1;
    first_vld = -1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (out_valid && first_vld < 0) first_vld = c;
      for (int w = 0; w < WIDTH; w++) begin
        if ((c - w) >= 0 && (c - w) < n && w != skip_col) begin
          ofm_vld[w] = 1'b1;
          ofm[w]     = rows[c-w][w];
        end else begin
          ofm_vld[w] = 1'b0;
          ofm[w]     = '0;
        end
      end
      out_ready = (c == pop_cyc);
    end
    @(negedge clk);
    if (out_valid && first_vld < 0) first_vld = last + 1;
    ofm_vld   = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bit bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_checks++; if (skew_err !== 1'b0) $display("FAIL reset_skew_err got %b want 0", skew_err); else n_pass++;
    bad = 0;
    for (int w = 0; w < WIDTH; w++) if (out_data[w] !== '0) bad = 1;
    n_checks++; if (bad) $display("FAIL reset_out_data got %p want zeros", out_data); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_row;
    bit bad;
    for (int w = 0; w < WIDTH; w++) rows[0][w] = w + 1;
    exp_q.push_back(exp_row(0));
    drive_rows(1, -1, -1, -1);
    n_checks++; if (first_vld != WIDTH + 1) $display("FAIL single_latency got cycle %0d want %0d", first_vld, WIDTH + 1); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        bad = 0;
        for (int w = 0; w < WIDTH; w++) if (out_data[w] !== exp_q[0][w]) bad = 1;
        n_checks++; if (bad) $display("FAIL single_data got %p want %p", out_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain rows left %0d want 0", exp_q.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_empty out_valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_fill_overflow;
    bit bad;
    for (int r = 0; r < 5; r++) for (int w = 0; w < WIDTH; w++) rows[r][w] = $urandom;
    for (int r = 0; r < 4; r++) exp_q.push_back(exp_row(r));
    drive_rows(5, -1, -1, -1);
    n_checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow got %b want 1", overflow); else n_pass++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fill_overflow_clr got %b want 0", overflow); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        bad = 0;
        for (int w = 0; w < WIDTH; w++) if (out_data[w] !== exp_q[0][w]) bad = 1;
        n_checks++; if (bad) $display("FAIL fill_data got %p want %p", out_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL fill_drain rows left %0d want 0", exp_q.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fill_empty out_valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_full_pop;
    bit bad;
    for (int r = 0; r < 5; r++) for (int w = 0; w < WIDTH; w++) rows[r][w] = $urandom;
    for (int r = 0; r < 5; r++) exp_q.push_back(exp_row(r));
    // Row 4 completes when the FIFO holds 4; pop the head in that same cycle.
    drive_rows(5, -1, 12, -1);
    void'(exp_q.pop_front());
    n_checks++; if (count !== 3'd4) $display("FAIL fullpop_count got %0d want 4", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %b want 0", overflow); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        bad = 0;
        for (int w = 0; w < WIDTH; w++) if (out_data[w] !== exp_q[0][w]) bad = 1;
        n_checks++; if (bad) $display("FAIL fullpop_data got %p want %p", out_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL fullpop_drain rows left %0d want 0", exp_q.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty out_valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_skew;
    bit bad;
    for (int w = 0; w < WIDTH; w++) rows[0][w] = 32'sd100 * w - 32'sd350;
    exp_q.push_back(exp_row(0));
    drive_rows(1, -1, -1, -1);
    // clr_err held through the skewed row: the set event must win.
    clr_err = 1'b1;
    for (int w = 0; w < WIDTH; w++) rows[0][w] = $urandom;
    drive_rows(1, 3, -1, -1);
    clr_err = 1'b0;
    n_checks++; if (skew_err !== 1'b1) $display("FAIL skew_set got %b want 1", skew_err); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL skew_count got %0d want 1", count); else n_pass++;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++; if (skew_err !== 1'b0) $display("FAIL skew_clr got %b want 0", skew_err); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        bad = 0;
        for (int w = 0; w < WIDTH; w++) if (out_data[w] !== exp_q[0][w]) bad = 1;
        n_checks++; if (bad) $display("FAIL skew_data got %p want %p", out_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL skew_drain rows left %0d want 0", exp_q.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL skew_empty out_valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_data_path;
    bit   bad;
    row_t e;
    rows[0][0] = 32'h7FFF_FFFF;
    rows[0][1] = 32'h8000_0000;
    rows[0][2] = 32'h0000_1280;
    rows[0][3] = 32'hFFFF_FE80;
    rows[0][4] = 32'h007F_FF80;
    rows[0][5] = 32'h0080_0000;
    rows[0][6] = 32'hFF80_0000;
    rows[0][7] = 32'hFF7F_FFFF;
`ifdef OFM_DRAIN_SAT_EN
    e[0] = 16'h7FFF; e[1] = 16'h8000; e[2] = 16'h0012; e[3] = 16'hFFFE;
    e[4] = 16'h7FFF; e[5] = 16'h7FFF; e[6] = 16'h8000; e[7] = 16'h8000;
`else
    for (int w = 0; w < WIDTH; w++) e[w] = rows[0][w];
`endif
    exp_q.push_back(e);
    drive_rows(1, -1, -1, -1);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        bad = 0;
        for (int w = 0; w < WIDTH; w++) if (out_data[w] !== exp_q[0][w]) bad = 1;
        n_checks++; if (bad) $display("FAIL datapath_data got %p want %p", out_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL datapath_drain rows left %0d want 0", exp_q.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL datapath_empty out_valid %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_midflight;
    bit saw_vld;
    for (int w = 0; w < WIDTH; w++) rows[0][w] = $urandom;
    exp_q.push_back(exp_row(0));
    drive_rows(1, -1, -1, -1);
    n_checks++; if (count !== 3'd1) $display("FAIL midrst_stored got %0d want 1", count); else n_pass++;
    // Two more rows only partway through the deskew when reset hits.
    for (int r = 0; r < 2; r++) for (int w = 0; w < WIDTH; w++) rows[r][w] = $urandom;
    drive_rows(2, -1, -1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_checks++; if (count !== 3'd0) $display("FAIL midrst_count got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
    saw_vld = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3 * WIDTH; k++) begin
      @(negedge clk);
      if (out_valid) saw_vld = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++; if (saw_vld !== 1'b0) $display("FAIL midrst_ghost_row got %b want 0", saw_vld); else n_pass++;
    n_checks++; if (skew_err !== 1'b0) $display("FAIL midrst_skew got %b want 0", skew_err); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    ofm_vld   = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    for (int w = 0; w < WIDTH; w++) ofm[w] = '0;
    test_reset();
    test_single_row();
    test_fill_overflow();
    test_full_pop();
    test_skew();
    test_data_path();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
